// File: rtl/xdma_write_beat_gen.sv
// ---------------------------------------------------------------------------
// xdma_write_beat_gen
//
// Purpose:
//   Upstream feeder of the xdma write demultiplexer. Takes one write-burst
//   descriptor (base address, byte stride, beat count) and a stream of data
//   beats, and emits one address+data pair per beat through a registered
//   valid/ready output stage. Sustains one beat per cycle.
//
// Ports:
//   clk_i          clock, all logic on the rising edge
//   rst_ni         synchronous active-low reset
//   desc_addr_i    base address of the first beat
//   desc_stride_i  unsigned byte increment between consecutive beats
//   desc_len_i     number of beats in the burst (0 = empty burst)
//   desc_valid_i   descriptor valid
//   desc_ready_o   descriptor accepted when high together with desc_valid_i
//   data_i         write data beat
//   data_valid_i   data beat valid
//   data_ready_o   data beat accepted when high together with data_valid_i
//   oup_addr_o     address of the output beat
//   oup_data_o     data of the output beat
//   oup_last_o     output beat is the last of its burst
//   oup_valid_o    output beat valid
//   oup_ready_i    downstream ready
//   busy_o         burst in progress or output register occupied
//   done_o         one-cycle pulse at burst completion
// ---------------------------------------------------------------------------
module xdma_write_beat_gen #(
  parameter int unsigned ADDR_WIDTH   = 48,
  parameter int unsigned DATA_WIDTH   = 512,
  parameter int unsigned LEN_WIDTH    = 16,
  parameter int unsigned STRIDE_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [ADDR_WIDTH-1:0]   desc_addr_i,
  input  logic [STRIDE_WIDTH-1:0] desc_stride_i,
  input  logic [LEN_WIDTH-1:0]    desc_len_i,
  input  logic                    desc_valid_i,
  output logic                    desc_ready_o,
  input  logic [DATA_WIDTH-1:0]   data_i,
  input  logic                    data_valid_i,
  output logic                    data_ready_o,
  output logic [ADDR_WIDTH-1:0]   oup_addr_o,
  output logic [DATA_WIDTH-1:0]   oup_data_o,
  output logic                    oup_last_o,
  output logic                    oup_valid_o,
  input  logic                    oup_ready_i,
  output logic                    busy_o,
  output logic                    done_o
);

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    BURST      = 2'd1,
    EMPTY_DONE = 2'd2
  } state_e;

  state_e                  state_q;
  state_e                  state_d;

  addr_t                   cur_addr_q;
  logic [STRIDE_WIDTH-1:0] stride_q;
  logic [LEN_WIDTH-1:0]    remaining_q;

  addr_t                   oup_addr_q;
  data_t                   oup_data_q;
  logic                    oup_last_q;
  logic                    oup_valid_q;
  logic                    done_q;

  logic                    desc_hs;
  logic                    data_hs;
  logic                    last_beat;
  logic                    empty_start;
  logic                    burst_start;
  logic                    oup_drain;
  addr_t                   stride_ext;

  // The stride is unsigned; the size cast zero-extends it so the address
  // addition wraps modulo 2^ADDR_WIDTH.
  assign stride_ext  = addr_t'(stride_q);
  assign last_beat   = (remaining_q == LEN_WIDTH'(1));
  assign oup_drain   = oup_valid_q && oup_ready_i;

  // desc_ready_o is only high in IDLE and data_ready_o only in BURST, so the
  // two handshakes can never coincide.
  assign desc_hs     = desc_valid_i && desc_ready_o;
  assign data_hs     = data_valid_i && data_ready_o;
  assign empty_start = desc_hs && (desc_len_i == '0);
  assign burst_start = desc_hs && (desc_len_i != '0);

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs. data_ready_o depends only on the
  // output register, never on data_valid_i, so no combinational path runs
  // from the data source back to itself. A new descriptor is accepted in
  // IDLE even if the previous last beat still waits in the output register;
  // the next burst simply cannot load until that register frees up.
  always_comb begin
    state_d      = state_q;
    desc_ready_o = 1'b0;
    data_ready_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        desc_ready_o = 1'b1;
        if (desc_valid_i) begin
          state_d = (desc_len_i == '0) ? EMPTY_DONE : BURST;
        end
      end
      BURST: begin
        data_ready_o = !oup_valid_q || oup_ready_i;
        if (data_valid_i && data_ready_o && last_beat) begin
          state_d = IDLE;
        end
      end
      EMPTY_DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Burst bookkeeping: latch the descriptor and step address/count per beat.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cur_addr_q  <= '0;
      stride_q    <= '0;
      remaining_q <= '0;
    end else if (burst_start) begin
      cur_addr_q  <= desc_addr_i;
      stride_q    <= desc_stride_i;
      remaining_q <= desc_len_i;
    end else if (data_hs) begin
      cur_addr_q  <= cur_addr_q + stride_ext;
      remaining_q <= remaining_q - LEN_WIDTH'(1);
    end
  end

  // Output register. A load and a drain in the same cycle simply replace
  // the beat, which is what gives one beat per cycle. Payload fields only
  // change on a load, so they stay stable while stalled.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      oup_valid_q <= 1'b0;
      oup_addr_q  <= '0;
      oup_data_q  <= '0;
      oup_last_q  <= 1'b0;
    end else if (data_hs) begin
      oup_valid_q <= 1'b1;
      oup_addr_q  <= cur_addr_q;
      oup_data_q  <= data_i;
      oup_last_q  <= last_beat;
    end else if (oup_drain) begin
      oup_valid_q <= 1'b0;
    end
  end

  // Completion pulse: the cycle after the last beat leaves, or the
  // EMPTY_DONE cycle for a zero-length burst.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      done_q <= 1'b0;
    end else begin
      done_q <= empty_start || (oup_drain && oup_last_q);
    end
  end

  assign oup_addr_o  = oup_addr_q;
  assign oup_data_o  = oup_data_q;
  assign oup_last_o  = oup_last_q;
  assign oup_valid_o = oup_valid_q;
  assign done_o      = done_q;
  assign busy_o      = (state_q != IDLE) || oup_valid_q;

endmodule
